// File: rtl/adder_error_monitor.sv
// adder_error_monitor: streaming error-metric accumulator placed behind an
// approximate adder. Each accepted sample is compared with the exact N-bit
// sum. Over a run of NUM_SAMPLES samples the block collects the error count,
// the saturating sum of error distances and the largest error distance.
// Optional feature macro: ADDER_ERR_BIAS_EN adds the signed, saturating
// bias_sum output.
module adder_error_monitor #(
   parameter int N           = 16,
   parameter int NUM_SAMPLES = 1024,
   parameter int CNT_W       = 32,
   parameter int ACC_W       = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [N-1:0]     approx_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [N-1:0]     max_ed
`ifdef ADDER_ERR_BIAS_EN
   ,
   output logic signed [ACC_W-1:0] bias_sum
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_SAMPLES);

   // Unsigned add that sticks at all-ones instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add_u(input logic [ACC_W-1:0] acc,
                                                  input logic [N-1:0]     inc);
      logic [ACC_W:0] s;
      s = {1'b0, acc} + {{(ACC_W+1-N){1'b0}}, inc};
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

`ifdef ADDER_ERR_BIAS_EN
   // Signed add that clamps to the most positive / most negative value.
   function automatic logic signed [ACC_W-1:0] sat_add_s(input logic signed [ACC_W-1:0] acc,
                                                         input logic signed [N:0]       inc);
      logic signed [ACC_W:0] s;
      s = {acc[ACC_W-1], acc} + {{(ACC_W-N){inc[N]}}, inc};
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
   endfunction
`endif

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              vld_p1_q, vld_p1_d;
   logic [N-1:0]      ed_p1_q, ed_p1_d;
   logic [CNT_W-1:0]  sample_count_q, sample_count_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [ACC_W-1:0]  sum_ed_q, sum_ed_d;
   logic [N-1:0]      max_ed_q, max_ed_d;
`ifdef ADDER_ERR_BIAS_EN
   logic signed [N:0]       diff_p1_q, diff_p1_d;
   logic signed [ACC_W-1:0] bias_sum_q, bias_sum_d;
`endif

   logic              accept_p0;
   logic [N-1:0]      exact_p0;
   logic signed [N:0] diff_p0;
   logic [N-1:0]      ed_p0;

   assign accept_p0 = in_valid && in_ready_q;

   // ---- stage 0: exact sum (carry dropped) and error distance ----
   always_comb begin
      exact_p0 = a + b;
      diff_p0  = signed'({1'b0, approx_sum}) - signed'({1'b0, exact_p0});
      ed_p0    = diff_p0[N] ? N'(-diff_p0) : diff_p0[N-1:0];
   end

   // Next-state for run control, stage-1 capture and stage-2 accumulation.
   always_comb begin
      state_d        = state_q;
      vld_p1_d       = accept_p0;
      ed_p1_d        = ed_p0;
      sample_count_d = sample_count_q;
      err_count_d    = err_count_q;
      sum_ed_d       = sum_ed_q;
      max_ed_d       = max_ed_q;
`ifdef ADDER_ERR_BIAS_EN
      diff_p1_d      = diff_p0;
      bias_sum_d     = bias_sum_q;
`endif

      // ---- stage 2: fold the registered sample into the accumulators ----
      if (vld_p1_q) begin
         if (ed_p1_q != '0) err_count_d = err_count_q + CNT_W'(1);
         sum_ed_d = sat_add_u(sum_ed_q, ed_p1_q);
         if (ed_p1_q > max_ed_q) max_ed_d = ed_p1_q;
`ifdef ADDER_ERR_BIAS_EN
         bias_sum_d = sat_add_s(bias_sum_q, diff_p1_q);
`endif
      end

      if (accept_p0) sample_count_d = sample_count_q + CNT_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_RUN;
               vld_p1_d       = 1'b0;
               sample_count_d = '0;
               err_count_d    = '0;
               sum_ed_d       = '0;
               max_ed_d       = '0;
`ifdef ADDER_ERR_BIAS_EN
               bias_sum_d     = '0;
`endif
            end
         end
         ST_RUN:   if (sample_count_d == NUM_C) state_d = ST_DRAIN;
         // Accumulators are final one edge after the last stage-1 valid.
         ST_DRAIN: if (!vld_p1_q) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_RUN) && (sample_count_d < NUM_C);
   end

   // ---- stage 1 register boundary; reset covers control and visible results ----
   always_ff @(posedge clk) begin
      ed_p1_q <= ed_p1_d;
`ifdef ADDER_ERR_BIAS_EN
      diff_p1_q <= diff_p1_d;
`endif
      if (rst) begin
         state_q        <= ST_IDLE;
         in_ready_q     <= 1'b0;
         vld_p1_q       <= 1'b0;
         sample_count_q <= '0;
         err_count_q    <= '0;
         sum_ed_q       <= '0;
         max_ed_q       <= '0;
`ifdef ADDER_ERR_BIAS_EN
         bias_sum_q     <= '0;
`endif
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         vld_p1_q       <= vld_p1_d;
         sample_count_q <= sample_count_d;
         err_count_q    <= err_count_d;
         sum_ed_q       <= sum_ed_d;
         max_ed_q       <= max_ed_d;
`ifdef ADDER_ERR_BIAS_EN
         bias_sum_q     <= bias_sum_d;
`endif
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done         = (state_q == ST_DONE);
   assign sample_count = sample_count_q;
   assign err_count    = err_count_q;
   assign sum_ed       = sum_ed_q;
   assign max_ed       = max_ed_q;
`ifdef ADDER_ERR_BIAS_EN
   assign bias_sum     = bias_sum_q;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor: three instances (NUM_SAMPLES 4 / 3 / 8,
// the last with ACC_W = 17) driven by directed and random runs and compared
// against a sample-list reference model.
module tb_adder_error_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  start_v, vld_v;
   logic [15:0] a, b, ap;
   logic [2:0]  rdy_v, busy_v, done_v;
   logic [31:0] sc0, sc1, sc2, ec0, ec1, ec2;
   logic [47:0] se0, se1;
   logic [16:0] se2;
   logic [15:0] mx0, mx1, mx2;
`ifdef ADDER_ERR_BIAS_EN
   logic signed [47:0] bs0, bs1;
   logic signed [16:0] bs2;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic        pv[$];
   logic [15:0] pa[$], pb[$], pap[$];

   adder_error_monitor #(.N(16), .NUM_SAMPLES(4), .CNT_W(32), .ACC_W(48)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(vld_v[0]), .in_ready(rdy_v[0]),
      .a(a), .b(b), .approx_sum(ap), .busy(busy_v[0]), .done(done_v[0]),
      .sample_count(sc0), .err_count(ec0), .sum_ed(se0), .max_ed(mx0)
`ifdef ADDER_ERR_BIAS_EN
      , .bias_sum(bs0)
`endif
   );

   adder_error_monitor #(.N(16), .NUM_SAMPLES(3), .CNT_W(32), .ACC_W(48)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(vld_v[1]), .in_ready(rdy_v[1]),
      .a(a), .b(b), .approx_sum(ap), .busy(busy_v[1]), .done(done_v[1]),
      .sample_count(sc1), .err_count(ec1), .sum_ed(se1), .max_ed(mx1)
`ifdef ADDER_ERR_BIAS_EN
      , .bias_sum(bs1)
`endif
   );

   adder_error_monitor #(.N(16), .NUM_SAMPLES(8), .CNT_W(32), .ACC_W(17)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(vld_v[2]), .in_ready(rdy_v[2]),
      .a(a), .b(b), .approx_sum(ap), .busy(busy_v[2]), .done(done_v[2]),
      .sample_count(sc2), .err_count(ec2), .sum_ed(se2), .max_ed(mx2)
`ifdef ADDER_ERR_BIAS_EN
      , .bias_sum(bs2)
`endif
   );

   function automatic logic [63:0] get_sc(input int s);
      case (s) 0: return 64'(sc0); 1: return 64'(sc1); default: return 64'(sc2); endcase
   endfunction
   function automatic logic [63:0] get_ec(input int s);
      case (s) 0: return 64'(ec0); 1: return 64'(ec1); default: return 64'(ec2); endcase
   endfunction
   function automatic logic [63:0] get_se(input int s);
      case (s) 0: return 64'(se0); 1: return 64'(se1); default: return 64'(se2); endcase
   endfunction
   function automatic logic [63:0] get_mx(input int s);
      case (s) 0: return 64'(mx0); 1: return 64'(mx1); default: return 64'(mx2); endcase
   endfunction
`ifdef ADDER_ERR_BIAS_EN
   function automatic logic signed [63:0] get_bs(input int s);
      case (s) 0: return 64'(bs0); 1: return 64'(bs1); default: return 64'(bs2); endcase
   endfunction
`endif

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic add(input logic v, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] apv);
      pv.push_back(v); pa.push_back(av); pb.push_back(bv); pap.push_back(apv);
   endtask

   task automatic clear_pat();
      pv.delete(); pa.delete(); pb.delete(); pap.delete();
   endtask

   task automatic check_zero(input int s, input string tag);
      check({tag, "_ready"}, rdy_v[s], 0);
      check({tag, "_busy"},  busy_v[s], 0);
      check({tag, "_done"},  done_v[s], 0);
      check({tag, "_count"}, get_sc(s), 0);
      check({tag, "_err"},   get_ec(s), 0);
      check({tag, "_sumed"}, get_se(s), 0);
      check({tag, "_maxed"}, get_mx(s), 0);
`ifdef ADDER_ERR_BIAS_EN
      check({tag, "_bias"},  get_bs(s), 0);
`endif
   endtask

   // Start a run on instance s, play the queued pattern one entry per cycle,
   // and, if the run completes, check latency and final metrics.
   task automatic run(input int s);
      int num, accw, acc, since, done_at, ex, d;
      longint merr, msum, mmax, cap;
      logic exp_rdy;
`ifdef ADDER_ERR_BIAS_EN
      longint mbias, bmax, bmin;
      mbias = 0;
`endif
      num  = (s == 0) ? 4 : (s == 1) ? 3 : 8;
      accw = (s == 2) ? 17 : 48;
      cap  = (64'sd1 <<< accw) - 1;
`ifdef ADDER_ERR_BIAS_EN
      bmax = (64'sd1 <<< (accw - 1)) - 1;
      bmin = -(64'sd1 <<< (accw - 1));
`endif
      merr = 0; msum = 0; mmax = 0; acc = 0; since = -1; done_at = -1;

      start_v[s] = 1'b1;
      vld_v      = '0;
      @(posedge clk); #1;
      start_v[s] = 1'b0;
      check("start_done",  done_v[s], 0);
      check("start_busy",  busy_v[s], 1);
      check("start_count", get_sc(s), 0);
      check("start_sumed", get_se(s), 0);

      for (int k = 0; k < pv.size(); k++) begin
         exp_rdy = (acc < num);
         check("in_ready", rdy_v[s], exp_rdy);
         a = pa[k]; b = pb[k]; ap = pap[k]; vld_v[s] = pv[k];
         @(posedge clk); #1;
         if (since >= 0) since++;
         if (pv[k] && exp_rdy) begin
            acc++;
            ex = (int'(pa[k]) + int'(pb[k])) & 32'hFFFF;
            d  = int'(pap[k]) - ex;
            if (d != 0) merr++;
            msum += (d < 0) ? -d : d;
            if (msum > cap) msum = cap;
            if (((d < 0) ? -d : d) > mmax) mmax = (d < 0) ? -d : d;
`ifdef ADDER_ERR_BIAS_EN
            mbias += d;
            if (mbias > bmax) mbias = bmax;
            if (mbias < bmin) mbias = bmin;
`endif
            if (acc == num) since = 1;
         end
         if (since >= 0 && done_v[s] && done_at < 0) done_at = since;
         check("sample_count", get_sc(s), acc);
      end
      vld_v[s] = 1'b0;

      if (acc == num) begin
         for (int w = 0; w < 10 && done_at < 0; w++) begin
            @(posedge clk); #1;
            since++;
            if (done_v[s]) done_at = since;
         end
         check("done_latency", done_at, 3);
         check("done_busy",    busy_v[s], 0);
         check("done_ready",   rdy_v[s], 0);
         check("final_count",  get_sc(s), num);
         check("err_count",    get_ec(s), merr);
         check("sum_ed",       get_se(s), msum);
         check("max_ed",       get_mx(s), mmax);
`ifdef ADDER_ERR_BIAS_EN
         check("bias_sum",     get_bs(s), mbias);
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] ra, rb, rex, rap;
      rst = 1'b1; start_v = '0; vld_v = '0; a = '0; b = '0; ap = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) check_zero(s, "reset");
      rst = 1'b0;

      // Exact run: approx equals a+b.
      clear_pat();
      add(1, 16'h1234, 16'h0F0F, 16'h2143);
      add(1, 16'h0001, 16'h0002, 16'h0003);
      add(1, 16'hFFFF, 16'h0001, 16'h0000);
      add(1, 16'h8000, 16'h8001, 16'h0001);
      run(0);
      check("exact_err", get_ec(0), 0);
      check("exact_sumed", get_se(0), 0);

      // Restart from DONE: wrap-around and one error.
      clear_pat();
      add(1, 16'hFFFF, 16'h0002, 16'h0001);
      add(1, 16'h0010, 16'h0010, 16'h0000);
      add(1, 16'h0003, 16'h0004, 16'h0007);
      add(1, 16'h0100, 16'h0001, 16'h0101);
      run(0);
      check("wrap_err", get_ec(0), 1);
      check("wrap_sumed", get_se(0), 32);
      check("wrap_maxed", get_mx(0), 32);

      // Error magnitude in both directions.
      clear_pat();
      add(1, 16'h0100, 16'h0200, 16'h0305);
      add(1, 16'h1000, 16'h0001, 16'h0FF8);
      add(1, 16'h0000, 16'h0000, 16'h0000);
      add(1, 16'h0002, 16'h0002, 16'h0004);
      run(0);
      check("mag_err", get_ec(0), 2);
      check("mag_sumed", get_se(0), 14);
      check("mag_maxed", get_mx(0), 9);
`ifdef ADDER_ERR_BIAS_EN
      check("mag_bias", get_bs(0), -4);
`endif

      // Gaps and backpressure: valid 1,0,1,1,1 with NUM_SAMPLES = 3.
      clear_pat();
      add(1, 16'h0001, 16'h0001, 16'h0003);
      add(0, 16'h0002, 16'h0002, 16'h0009);
      add(1, 16'h0002, 16'h0002, 16'h0004);
      add(1, 16'h0005, 16'h0005, 16'h000A);
      add(1, 16'h0000, 16'h0000, 16'h00FF);
      run(1);
      check("bp_count", get_sc(1), 3);
      check("bp_maxed", get_mx(1), 1);

      // Reset in the middle of a run, then a clean run.
      clear_pat();
      add(1, 16'h0001, 16'h0001, 16'h0007);
      add(1, 16'h0002, 16'h0002, 16'h0000);
      run(0);
      check("mid_busy", busy_v[0], 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero(0, "midrst");
      clear_pat();
      for (int k = 0; k < 4; k++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         add(1, ra, rb, ra + rb + 16'd3);
      end
      run(0);
      check("after_rst_sumed", get_se(0), 12);

      // Saturation with ACC_W = 17: eight samples of ED = 0xFFFF.
      clear_pat();
      for (int k = 0; k < 8; k++) begin
         ra = 16'($urandom);
         add(1, ra, 16'(-ra), 16'hFFFF);
      end
      run(2);
      check("sat_sumed", get_se(2), 64'h1FFFF);
      check("sat_maxed", get_mx(2), 64'hFFFF);

      // Randomized runs with gaps; the final four entries are always valid.
      for (int r = 0; r < 6; r++) begin
         clear_pat();
         for (int k = 0; k < 12; k++) begin
            ra  = 16'($urandom); rb = 16'($urandom); rex = ra + rb;
            case ($urandom_range(0, 3))
               0:       rap = rex;
               1:       rap = rex + 16'($urandom_range(1, 300));
               2:       rap = rex - 16'($urandom_range(1, 300));
               default: rap = 16'($urandom);
            endcase
            add((k >= 8) ? 1'b1 : 1'($urandom_range(0, 1)), ra, rb, rap);
         end
         run(0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_error_monitor.md
Name: adder_error_monitor

Overview:
- Synthesizable streaming error-metric accumulator placed directly downstream of an approximate adder under test (e.g. the CPETA instance).
- Per sample: consumes operands A, B and the approximate sum; computes the exact N-bit sum internally.
- Over a programmed run of NUM_SAMPLES it accumulates error count, total error distance and maximum error distance.
- Lets on-chip or FPGA evaluation produce the inputs for ER, MED and NMED without a simulator.

Parameters:
- N, 16, operand and sum width.
- NUM_SAMPLES, 1024, samples per run; must be ≥ 1.
- CNT_W, 32, width of err_count and sample_count.
- ACC_W, 48, width of the sum_ed accumulator.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a run from IDLE or DONE.
- in_valid, input, 1, sample valid.
- in_ready, output, 1, monitor can accept a sample.
- a, input, N, operand A given to the adder.
- b, input, N, operand B given to the adder.
- approx_sum, input, N, sum produced by the approximate adder.
- busy, output, 1, run in progress (RUN or DRAIN).
- done, output, 1, results valid; held until next start or rst.
- sample_count, output, CNT_W, samples accepted this run.
- err_count, output, CNT_W, samples with approx_sum ≠ exact sum.
- sum_ed, output, ACC_W, sum of error distances; saturating.
- max_ed, output, N, largest error distance seen this run.

Behaviour:
- Reset (synchronous, active-high, highest priority, valid in any state, including mid-run): state = IDLE; pipeline valid bits cleared; every output = 0.
- Exact sum: (a + b) mod 2^N; carry-out discarded.
- ED = |approx_sum − exact|, N-bit unsigned magnitude.
- Handshake:
  - A sample transfers on a cycle where in_valid && in_ready.
  - in_ready is registered and high only in RUN while sample_count < NUM_SAMPLES.
  - Data is ignored when in_ready = 0.
- Pipeline:
  - Stage 1 (cycle t+1): register exact sum and ED, plus a valid bit.
  - Stage 2 (cycle t+2): update accumulators.
  - sample_count increments at t+1 (on acceptance).
- Accumulator updates at stage 2:
  - err_count += 1 if ED ≠ 0.
  - sum_ed += ED; saturates at 2^ACC_W − 1 and never wraps.
  - max_ed = ED if ED > max_ed.
- States:
  - IDLE: in_ready = 0, busy = 0, done = 0. start → clear all counters and accumulators, go to RUN.
  - RUN: busy = 1; in_ready = 1 until NUM_SAMPLES samples are accepted. The cycle the final sample is accepted, in_ready drops next edge and state goes to DRAIN. start is ignored.
  - DRAIN: busy = 1, in_ready = 0. After both pipeline valid bits clear (2 cycles), go to DONE. start is ignored.
  - DONE: done = 1, busy = 0; outputs frozen. start → clear everything, done = 0 next cycle, go to RUN.
- Back-to-back samples at one per cycle are supported; in_valid gaps simply stall counting.
- Worst-case run latency: the last sample accepted at cycle t gives done = 1 at cycle t+3.
- start and rst in the same cycle: rst wins.

Optional Feature:
- Macro: ADDER_ERR_BIAS_EN.
- Defined:
  - Adds output bias_sum (signed, ACC_W bits), reset 0, cleared on start.
  - Accumulates signed approx_sum − exact as an (N+1)-bit signed value at stage 2.
  - Saturates at the most positive and most negative representable values.
  - Used to measure mean error bias.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Exact run: N = 16, NUM_SAMPLES = 4; samples with approx_sum = a + b, e.g. (0x1234, 0x0F0F, 0x2143) → done at last-accept + 3; err_count = 0, sum_ed = 0, max_ed = 0, sample_count = 4.
- Wrap and error: a = 0xFFFF, b = 0x0002, approx = 0x0001 → ED = 0. a = 0x0010, b = 0x0010, approx = 0x0000 → ED = 0x20. Expect err_count = 1, sum_ed = 32, max_ed = 32.
- Magnitude both directions: approx = exact + 5, then approx = exact − 9 → sum_ed = 14, max_ed = 9, err_count = 2. With ADDER_ERR_BIAS_EN, bias_sum = −4.
- Backpressure and gaps: NUM_SAMPLES = 3, in_valid toggled 1,0,1,1,1 → exactly 3 accepted; in_ready low from the cycle after the 3rd accept; the 5th sample is not counted.
- Reset mid-run: rst asserted in RUN after 2 samples → next cycle all outputs 0, state IDLE. A later start runs cleanly from zero.
- Restart from DONE: start in DONE → done = 0 next cycle, counters cleared, new run accumulates independently. Saturation check with ACC_W = 17, eight samples of ED = 0xFFFF → sum_ed = 0x1FFFF.
